// File: rtl/top_sseg_mux.sv
// Four-digit multiplexed hex driver for a common-anode 7-segment display.
// Scans positions 0..3, each lit DIGIT_CYCLES clocks; outputs are registered and active-low.
module top_sseg_mux #(
   parameter int DIGIT_CYCLES = 100000,
   parameter int CNT_W        = 17
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] digit0,
   input  logic [3:0] digit1,
   input  logic [3:0] digit2,
   input  logic [3:0] digit3,
   output logic [3:0] sseg_an,
   output logic [6:0] sseg_ca
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGIT_CYCLES - 1);

   logic [CNT_W-1:0] cnt;
   logic [1:0]       sel;
   logic [3:0]       cur;
   logic [6:0]       seg;

   // Pick the nibble for the position currently being scanned.
   always_comb begin
      cur = digit0;
      case (sel)
         2'd0: cur = digit0;
         2'd1: cur = digit1;
         2'd2: cur = digit2;
         2'd3: cur = digit3;
         default: cur = digit0;
      endcase
   end

   // Hex to active-low segment pattern, bits g..a.
   always_comb begin
      seg = 7'b1111111;
      case (cur)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'ha: seg = 7'b0001000;
         4'hb: seg = 7'b0000011;
         4'hc: seg = 7'b1000110;
         4'hd: seg = 7'b0100001;
         4'he: seg = 7'b0000110;
         4'hf: seg = 7'b0001110;
         default: seg = 7'b1111111;
      endcase
   end

   // Refresh counter; wrapping it advances the scanned position.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         sel <= 2'd0;
      end else if (cnt == LAST) begin
         cnt <= '0;
         sel <= sel + 2'd1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Register anode and cathode drive from the pre-edge position.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sseg_an <= 4'b1111;
         sseg_ca <= 7'b1111111;
      end else begin
         sseg_an <= ~(4'b0001 << sel);
         sseg_ca <= seg;
      end
   end

endmodule

// File: tb/tb_top_sseg_mux.sv
// Scoreboard bench for top_sseg_mux with a short refresh period.
// Driver pushes expected an/ca per edge; a monitor pops and compares after each edge.
module tb_top_sseg_mux;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       clk_en = 1'b0;
   logic       rst;
   logic [3:0] digit0, digit1, digit2, digit3;
   logic [3:0] sseg_an;
   logic [6:0] sseg_ca;

   int errors = 0;
   int checks = 0;
   int k = 0;
   bit done = 0;

   logic [10:0] exp_q[$];
   logic [6:0]  seg_tab[16];

   top_sseg_mux #(.DIGIT_CYCLES(D), .CNT_W(3)) dut (
      .clk(clk), .rst(rst),
      .digit0(digit0), .digit1(digit1),
      .digit2(digit2), .digit3(digit3),
      .sseg_an(sseg_an), .sseg_ca(sseg_ca)
   );

   initial forever #5 clk = clk_en ? ~clk : 1'b0;

   task automatic chk(string name, logic [10:0] act, logic [10:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: an/ca got %b/%b want %b/%b",
                  name, act[10:7], act[6:0], want[10:7], want[6:0]);
      end
   endtask

   // Reference: after the k-th edge since release, position (k/D)%4 is lit.
   task automatic drive_push(input bit rnd, input logic [15:0] fixed);
      logic [3:0] d[4];
      int p;
      if (rnd) begin
         {digit3, digit2, digit1, digit0} = 16'($urandom);
      end else begin
         {digit3, digit2, digit1, digit0} = fixed;
      end
      d[0] = digit0; d[1] = digit1; d[2] = digit2; d[3] = digit3;
      p = (k / D) % 4;
      exp_q.push_back({4'b1111 & ~(4'(1) << p), seg_tab[d[p]]});
      k++;
   endtask

   // Monitor: compare every edge that has an expectation queued.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) chk("scan", {sseg_an, sseg_ca}, exp_q.pop_front());
   end

   initial begin
      #20000;
      $display("FAIL timeout: done=%0d want 1", done);
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1);
   end

   initial begin
      seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      {digit3, digit2, digit1, digit0} = 16'h3210;
      rst = 1'b0;
      #2 rst = 1'b1;
      #1 chk("reset_noclk", {sseg_an, sseg_ca}, 11'h7ff);
      clk_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      k = 0;
      drive_push(0, 16'h3210);
      for (int i = 0; i < 4 * D * 2 - 1; i++) begin
         @(negedge clk);
         drive_push(0, 16'h3210);
      end
      // Sweep all hex values on every position over several periods.
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         drive_push(0, {4'(i + 3), 4'(i + 2), 4'(i + 1), 4'(i)});
      end
      for (int i = 0; i < 130; i++) begin
         @(negedge clk);
         drive_push(1, 16'h0);
      end
      // Advance until position 2 is on display, then reset between edges.
      while (((k - 1) / D) % 4 != 2) begin
         @(negedge clk);
         drive_push(1, 16'h0);
      end
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("reset_async", {sseg_an, sseg_ca}, 11'h7ff);
      exp_q.push_back(11'h7ff);
      @(negedge clk);
      exp_q.push_back(11'h7ff);
      @(negedge clk);
      rst = 1'b0;
      k = 0;
      drive_push(1, 16'h0);
      for (int i = 0; i < 4 * D * 3; i++) begin
         @(negedge clk);
         drive_push(1, 16'h0);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: queue size %0d want 0", exp_q.size());
      end
      done = 1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
